// File: rtl/axi4_arb_pkg.sv
// Shared definitions for the two-client AXI4-lite read arbiter.
//   arb_state_e       : arbiter FSM states (IDLE / BUSY / RESP)
//   CLIENT_IFU/LSU    : client index constants used for grant and routing
//   ERR_DATA_DEFAULT  : data pattern returned to a client on watchdog timeout
package axi4_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    localparam logic CLIENT_IFU = 1'b0;
    localparam logic CLIENT_LSU = 1'b1;

    localparam logic [63:0] ERR_DATA_DEFAULT = 64'hDEAD_BEEF_DEAD_BEEF;

endpackage

// File: rtl/axi4_rr_pick.sv
// Combinational two-way round-robin winner selection.
//   req_i        in  2  request vector {C1_Req, C0_Req}
//   last_grant_i in  1  client granted most recently
//   valid_o      out 1  at least one request present
//   winner_o     out 1  index of the winning client
module axi4_rr_pick
    import axi4_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic       valid_o,
    output logic       winner_o
);

    always_comb begin
        valid_o = |req_i;
        // On a tie the client that was not served last goes first;
        // a lone requester wins outright.
        if (&req_i) begin
            winner_o = ~last_grant_i;
        end else begin
            winner_o = req_i[1] ? CLIENT_LSU : CLIENT_IFU;
        end
    end

endmodule

// File: rtl/axi4_read_arbiter.sv
// Two-client (IFU / LSU) read arbiter in front of the AXI4-lite read module.
// Grants one level-held request at a time round-robin, drives the single
// R_Addr/R_Request port, routes R_Finish/Data_Out back to the granted client
// as a one-cycle Ack with registered data, and forces completion with
// ERR_DATA if the read module does not answer within TIMEOUT_CYCLES.
//   CLK, RST_N             clock, synchronous active-low reset
//   C0_Req/Addr, Ack/Data  IFU request in, completion out
//   C1_Req/Addr, Ack/Data  LSU request in, completion out
//   R_Addr, R_Request      request to the read module (level)
//   R_Finish, Data_Out     completion pulse and data from the read module
//   Busy                   transaction in flight (BUSY or RESP)
//   Err                    sticky watchdog timeout flag
module axi4_read_arbiter
    import axi4_arb_pkg::*;
#(
    parameter int                ADDR_W         = 64,
    parameter int                DATA_W         = 64,
    parameter int                TIMEOUT_CYCLES = 1024,
    parameter logic [DATA_W-1:0] ERR_DATA       = DATA_W'(ERR_DATA_DEFAULT)
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              C0_Req,
    input  logic [ADDR_W-1:0] C0_Addr,
    output logic              C0_Ack,
    output logic [DATA_W-1:0] C0_Data,
    input  logic              C1_Req,
    input  logic [ADDR_W-1:0] C1_Addr,
    output logic              C1_Ack,
    output logic [DATA_W-1:0] C1_Data,
    output logic [ADDR_W-1:0] R_Addr,
    output logic              R_Request,
    input  logic              R_Finish,
    input  logic [DATA_W-1:0] Data_Out,
    output logic              Busy,
    output logic              Err
);

    // One extra bit so the counter can sit one past the last compare value
    // and saturate instead of wrapping.
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam bit WDOG_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_e        state_q;
    logic              grant_q;
    logic              last_grant_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [ADDR_W-1:0] r_addr_q;
    logic              r_req_q;
    logic              c0_ack_q;
    logic              c1_ack_q;
    logic [DATA_W-1:0] c0_data_q;
    logic [DATA_W-1:0] c1_data_q;
    logic              busy_q;
    logic              err_q;

    logic              pick_valid;
    logic              pick_winner;
    logic              timeout_hit;
    logic [DATA_W-1:0] resp_data;

    axi4_rr_pick u_pick (
        .req_i        ({C1_Req, C0_Req}),
        .last_grant_i (last_grant_q),
        .valid_o      (pick_valid),
        .winner_o     (pick_winner)
    );

    always_comb begin
        cnt_d       = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
        timeout_hit = WDOG_EN && (cnt_q == CNT_LAST);
        // A real completion always beats a coincident timeout.
        resp_data   = R_Finish ? Data_Out : ERR_DATA;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q      <= IDLE;
            grant_q      <= CLIENT_IFU;
            last_grant_q <= CLIENT_LSU;
            cnt_q        <= '0;
            r_addr_q     <= '0;
            r_req_q      <= 1'b0;
            c0_ack_q     <= 1'b0;
            c1_ack_q     <= 1'b0;
            c0_data_q    <= '0;
            c1_data_q    <= '0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        r_addr_q <= (pick_winner == CLIENT_LSU) ? C1_Addr : C0_Addr;
                        r_req_q  <= 1'b1;
                        grant_q  <= pick_winner;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= BUSY;
                    end
                end
                BUSY: begin
                    // Client request level is not looked at here: once
                    // granted, the transaction always runs to an Ack.
                    if (R_Finish || timeout_hit) begin
                        r_req_q <= 1'b0;
                        if (grant_q == CLIENT_LSU) begin
                            c1_data_q <= resp_data;
                            c1_ack_q  <= 1'b1;
                        end else begin
                            c0_data_q <= resp_data;
                            c0_ack_q  <= 1'b1;
                        end
                        if (!R_Finish) begin
                            err_q <= 1'b1;
                        end
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                RESP: begin
                    // Requests are not sampled here, which gives the client
                    // one cycle after its Ack to drop Req.
                    c0_ack_q     <= 1'b0;
                    c1_ack_q     <= 1'b0;
                    last_grant_q <= grant_q;
                    busy_q       <= 1'b0;
                    state_q      <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign R_Addr    = r_addr_q;
    assign R_Request = r_req_q;
    assign C0_Ack    = c0_ack_q;
    assign C1_Ack    = c1_ack_q;
    assign C0_Data   = c0_data_q;
    assign C1_Data   = c1_data_q;
    assign Busy      = busy_q;
    assign Err       = err_q;

endmodule

// File: tb/tb_axi4_read_arbiter.sv
// Testbench for axi4_read_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level reference model.
module tb_axi4_read_arbiter;

    localparam int          TO   = 8;
    localparam logic [63:0] ERRD = 64'hDEAD_BEEF_DEAD_BEEF;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        C0_Req = 1'b0;
    logic [63:0] C0_Addr = '0;
    logic        C0_Ack;
    logic [63:0] C0_Data;
    logic        C1_Req = 1'b0;
    logic [63:0] C1_Addr = '0;
    logic        C1_Ack;
    logic [63:0] C1_Data;
    logic [63:0] R_Addr;
    logic        R_Request;
    logic        R_Finish = 1'b0;
    logic [63:0] Data_Out = '0;
    logic        Busy;
    logic        Err;

    axi4_read_arbiter #(
        .ADDR_W         (64),
        .DATA_W         (64),
        .TIMEOUT_CYCLES (TO),
        .ERR_DATA       (ERRD)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .C0_Req    (C0_Req),
        .C0_Addr   (C0_Addr),
        .C0_Ack    (C0_Ack),
        .C0_Data   (C0_Data),
        .C1_Req    (C1_Req),
        .C1_Addr   (C1_Addr),
        .C1_Ack    (C1_Ack),
        .C1_Data   (C1_Data),
        .R_Addr    (R_Addr),
        .R_Request (R_Request),
        .R_Finish  (R_Finish),
        .Data_Out  (Data_Out),
        .Busy      (Busy),
        .Err       (Err)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;
    int txn_no = 0;

    // Reference model state: who was served last, sticky error, and the
    // data each client should currently be presenting.
    int          last_win;
    bit          err_m;
    logic [63:0] data_m [2];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic model_reset();
        last_win  = 1;
        err_m     = 1'b0;
        data_m[0] = '0;
        data_m[1] = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_rreq"}, 64'(R_Request), 64'(0));
        check_eq({tag, "_raddr"}, R_Addr, 64'(0));
        check_eq({tag, "_acks"}, 64'({C1_Ack, C0_Ack}), 64'(0));
        check_eq({tag, "_c0data"}, C0_Data, 64'(0));
        check_eq({tag, "_c1data"}, C1_Data, 64'(0));
        check_eq({tag, "_busy"}, 64'(Busy), 64'(0));
        check_eq({tag, "_err"}, 64'(Err), 64'(0));
    endtask

    // Called at the negedge of an IDLE cycle. Presents the requests, plays
    // the read module (R_Finish 'lat' cycles after R_Request rises, 0 = never)
    // and checks the Ack cycle against the model. Returns at the negedge of
    // the following IDLE cycle.
    task automatic run_txn(input bit r0, input bit r1, input logic [63:0] a0,
                           input logic [63:0] a1, input int lat,
                           input logic [63:0] rdata, input bit hold);
        int          win;
        int          exp_k;
        int          k;
        bit          timed_out;
        bit          seen;
        bit          steady;
        logic [63:0] exp_addr;
        R_Finish = 1'b0;
        check_eq("idle_rreq", 64'(R_Request), 64'(0));
        check_eq("idle_busy", 64'(Busy), 64'(0));
        check_eq("idle_acks", 64'({C1_Ack, C0_Ack}), 64'(0));
        C0_Req  = r0;
        C1_Req  = r1;
        C0_Addr = a0;
        C1_Addr = a1;
        win       = (r0 && r1) ? 1 - last_win : (r1 ? 1 : 0);
        exp_addr  = (win == 1) ? a1 : a0;
        timed_out = !(lat >= 1 && lat <= TO - 1);
        // Ack cycle measured from the cycle R_Request first shows high.
        exp_k     = timed_out ? TO : lat + 1;
        tick();
        check_eq("rreq_rise", 64'(R_Request), 64'(1));
        check_eq("raddr", R_Addr, exp_addr);
        check_eq("busy_on", 64'(Busy), 64'(1));
        k      = 0;
        seen   = 1'b0;
        steady = 1'b1;
        while (!seen && k <= TO + 4) begin
            if (C0_Ack || C1_Ack) begin
                seen = 1'b1;
            end else begin
                if (R_Request !== 1'b1 || R_Addr !== exp_addr) steady = 1'b0;
                R_Finish = (lat > 0 && k == lat);
                Data_Out = R_Finish ? rdata : {$urandom, $urandom};
                tick();
                k++;
            end
        end
        last_win = win;
        if (timed_out) begin
            err_m       = 1'b1;
            data_m[win] = ERRD;
        end else begin
            data_m[win] = rdata;
        end
        check_eq("ack_seen", 64'(seen), 64'(1));
        if (seen) begin
            check_eq("ack_cycle", 64'(k), 64'(exp_k));
            check_eq("ack_vec", 64'({C1_Ack, C0_Ack}), 64'((win == 1) ? 2'b10 : 2'b01));
            check_eq("ack_data", (win == 1) ? C1_Data : C0_Data, data_m[win]);
            check_eq("other_data", (win == 1) ? C0_Data : C1_Data, data_m[1 - win]);
            check_eq("err", 64'(Err), 64'(err_m));
            check_eq("rreq_low_ack", 64'(R_Request), 64'(0));
            check_eq("busy_resp", 64'(Busy), 64'(1));
            check_eq("rreq_steady", 64'(steady), 64'(1));
        end
        // A finish landing in the Ack cycle is a late response and must be ignored.
        R_Finish = (lat > 0 && k == lat);
        Data_Out = {$urandom, $urandom};
        if (!hold) begin
            if (win == 1) C1_Req = 1'b0;
            else          C0_Req = 1'b0;
        end
        txn_no++;
        $display("[TB] txn %0d: client %0d addr 0x%h lat %0d -> data 0x%h %s",
                 txn_no, win, exp_addr, lat, data_m[win], timed_out ? "timeout" : "normal");
        tick();
    endtask

    task automatic do_reset();
        RST_N    = 1'b0;
        C0_Req   = 1'b0;
        C1_Req   = 1'b0;
        R_Finish = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        RST_N = 1'b1;
        model_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        bit          pend [2];
        logic [63:0] addr [2];
        int          nreq;
        int          lat;
        bit          hold;
        int          w;
        bit          any_ack;

        model_reset();
        tick();
        do_reset();

        // Single IFU read
        run_txn(1'b1, 1'b0, 64'h8000_0000, 64'h0, 2, 64'h1122_3344_5566_7788, 1'b0);

        // Ties after reset alternate 0,1,0,1
        do_reset();
        run_txn(1'b1, 1'b1, 64'h100, 64'h200, 1, 64'hA0, 1'b0);
        run_txn(1'b0, 1'b1, 64'h100, 64'h200, 3, 64'hA1, 1'b0);
        run_txn(1'b1, 1'b1, 64'h100, 64'h200, 2, 64'hA2, 1'b0);
        run_txn(1'b0, 1'b1, 64'h100, 64'h200, 1, 64'hA3, 1'b0);

        // Timeout on LSU, then a late finish in IDLE is ignored
        run_txn(1'b0, 1'b1, 64'h0, 64'h300, 0, 64'h0, 1'b0);
        R_Finish = 1'b1;
        Data_Out = 64'h5555_6666_7777_8888;
        tick();
        R_Finish = 1'b0;
        any_ack = 1'b0;
        repeat (3) begin
            if (C0_Ack || C1_Ack) any_ack = 1'b1;
            tick();
        end
        check_eq("late_no_ack", 64'(any_ack), 64'(0));
        check_eq("late_busy", 64'(Busy), 64'(0));
        check_eq("late_rreq", 64'(R_Request), 64'(0));
        check_eq("err_sticky", 64'(Err), 64'(1));
        check_eq("late_c1data", C1_Data, ERRD);

        // Back-to-back: IFU holds Req through its Ack and is re-granted at f+3
        run_txn(1'b1, 1'b0, 64'h4000, 64'h0, 1, 64'hB0, 1'b1);
        run_txn(1'b1, 1'b0, 64'h4000, 64'h0, 3, 64'hB1, 1'b0);

        // Reset while BUSY abandons the read without an Ack
        R_Finish = 1'b0;
        C0_Req   = 1'b1;
        C0_Addr  = 64'h9000;
        tick();
        check_eq("mid_rreq", 64'(R_Request), 64'(1));
        RST_N = 1'b0;
        tick();
        check_all_zero("midrst");
        RST_N  = 1'b1;
        C0_Req = 1'b0;
        model_reset();
        any_ack = 1'b0;
        repeat (4) begin
            tick();
            if (C0_Ack || C1_Ack || R_Request) any_ack = 1'b1;
        end
        check_eq("midrst_quiet", 64'(any_ack), 64'(0));

        // Randomized traffic; a pending client keeps Req and address until served
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        addr[0] = '0;
        addr[1] = '0;
        for (int t = 0; t < 50; t++) begin
            nreq = $urandom_range(0, 3);
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && nreq[i]) begin
                    pend[i] = 1'b1;
                    addr[i] = {$urandom, $urandom};
                end
            end
            if (!pend[0] && !pend[1]) begin
                w       = $urandom_range(0, 1);
                pend[w] = 1'b1;
                addr[w] = {$urandom, $urandom};
            end
            lat  = $urandom_range(0, TO);
            hold = ($urandom_range(0, 3) == 0);
            w    = (pend[0] && pend[1]) ? 1 - last_win : (pend[1] ? 1 : 0);
            run_txn(pend[0], pend[1], addr[0], addr[1], lat, {$urandom, $urandom}, hold);
            if (!hold) pend[w] = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axi4_read_arbiter.md
# axi4_read_arbiter

Two-client read arbiter sitting directly upstream of the AXI4-lite read module: it takes level-held read requests from the IFU (client 0) and LSU (client 1), grants one at a time round-robin, and drives the single host-side request port (R_Addr/R_Request) of the read module. It consumes R_Finish/Data_Out, routes the returned data to the granted client with a one-cycle acknowledge, and guards each transaction with a watchdog timeout.

## Interface

Parameters:
- ADDR_W, 64, address width
- DATA_W, 64, data width
- TIMEOUT_CYCLES, 1024, max cycles in BUSY before forced completion; 0 disables the watchdog
- ERR_DATA, 64'hDEAD_BEEF_DEAD_BEEF, data returned on timeout

Ports:
- CLK  in  1  clock, all logic on rising edge
- RST_N  in  1  synchronous, active-low reset
- C0_Req  in  1  IFU read request, held until C0_Ack
- C0_Addr  in  ADDR_W  IFU address, stable while C0_Req
- C0_Ack  out  1  one-cycle completion pulse to IFU
- C0_Data  out  DATA_W  read data, valid when C0_Ack
- C1_Req / C1_Addr / C1_Ack / C1_Data  same as client 0, for LSU
- R_Addr  out  ADDR_W  address to read module
- R_Request  out  1  request to read module, level
- R_Finish  in  1  read module completion pulse
- Data_Out  in  DATA_W  read module data, valid with R_Finish
- Busy  out  1  high in BUSY or RESP
- Err  out  1  sticky timeout flag, cleared only by reset

## Operation

- FSM states: IDLE, BUSY, RESP.
- IDLE: if any Cx_Req high, pick winner, register R_Addr <= winner address, R_Request <= 1, grant <= winner, clear watchdog counter, go BUSY. No request: stay.
- Arbitration: single request wins outright; both high → client not granted last (last_grant). last_grant resets to 1, so client 0 wins the first tie.
- BUSY: R_Request and R_Addr held constant. On R_Finish: latch Data_Out into granted Cx_Data, R_Request <= 0, Cx_Ack <= 1, go RESP. Otherwise increment counter; when counter == TIMEOUT_CYCLES−1 (and TIMEOUT_CYCLES != 0) without R_Finish: Cx_Data <= ERR_DATA, Err <= 1, R_Request <= 0, Cx_Ack <= 1, go RESP.
- RESP: one cycle; Cx_Ack deasserts, update last_grant, go IDLE. Requests are not sampled in RESP.
- Cx_Data retains last value between transactions; non-granted client's Data/Ack never change.
- R_Finish in IDLE or RESP (late response after timeout) is ignored; no state change.
- Req changes or drops while granted: ignored; the transaction completes and acks anyway.
- Counter width: clog2(TIMEOUT_CYCLES)+1, saturates, never wraps.

## Timing

- Reset (RST_N low at a rising edge): state IDLE, R_Request 0, R_Addr 0, C0/C1_Ack 0, C0/C1_Data 0, Busy 0, Err 0, last_grant 1, counter 0. Applies mid-transaction; an in-flight read is abandoned.
- Request seen in IDLE at edge t → R_Request high from t+1.
- R_Finish high at cycle f → Cx_Ack high and Cx_Data valid in cycle f+1 only; R_Request low from f+1; IDLE from f+2.
- Earliest next grant sampled at f+2 → next R_Request at f+3. Minimum request-to-ack latency: 3 cycles when R_Finish arrives the cycle after R_Request.
- Client must drop Cx_Req no later than the cycle after its Ack, else it is re-granted.

## Structure

- Shared package axi4_arb_pkg: state enum (IDLE/BUSY/RESP), client index constants CLIENT_IFU=0 / CLIENT_LSU=1, default ERR_DATA.
- One sub-module: axi4_rr_pick — combinational 2-way round-robin winner from {C1_Req, C0_Req} and last_grant; outputs valid and winner index. FSM, counter and data routing stay in the top.

## Test plan

- Single IFU: C0_Req, C0_Addr=0x8000_0000; R_Finish 2 cycles after R_Request with Data_Out=0x1122334455667788 → R_Addr=0x8000_0000, C0_Ack one cycle, C0_Data=0x1122334455667788, C1_Ack stays 0.
- Tie: both Req at once after reset, addr 0x100/0x200 → first grant 0x100 (client 0), second 0x200 (client 1); repeat tie → alternates 0,1,0,1.
- Timeout: TIMEOUT_CYCLES=8, C1_Req, never R_Finish → C1_Ack 8 cycles after R_Request rise, C1_Data=ERR_DATA, Err=1 and stays 1; a late R_Finish afterwards produces no Ack.
- Back-to-back: C0_Req held through its Ack → R_Request low for exactly two cycles (f+1, f+2) then re-asserted at f+3.
- Reset mid-BUSY: RST_N low one cycle while R_Request=1 → all outputs 0 next cycle, state IDLE, Err 0, no Ack emitted.
